// File: rtl/p3p_pkg.sv
// Shared types and constants for the numeric UART transmitter.
// A num is a raw 16-bit two's-complement value carried as two bytes.
package p3p_pkg;

    typedef logic signed [15:0] num;

    localparam int CLK_HZ               = 32'd50_000_000;
    localparam int BAUD_RATE            = 32'd115_200;
    localparam int DEFAULT_CLKS_PER_BIT = CLK_HZ / BAUD_RATE;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

    // Select the low (hi=0) or high (hi=1) byte of a num, no sign handling.
    function automatic logic [7:0] num_byte(input num value, input logic hi);
        if (hi) begin
            num_byte = value[15:8];
        end else begin
            num_byte = value[7:0];
        end
    endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// 8N1 single-byte serializer. o_ready is also high in the final stop-bit
// cycle so a new byte can follow with no idle gap.
module uart_byte_tx
    import p3p_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_start,
    input  logic [7:0] i_data,
    output logic       o_ready,
    output logic       o_tx
);

    localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    tx_state_t         r_state;
    tx_state_t         w_state_nx;
    logic [BAUD_W-1:0] r_baud;
    logic [BAUD_W-1:0] w_baud_nx;
    logic [2:0]        r_bit;
    logic [2:0]        w_bit_nx;
    logic [7:0]        r_shift;
    logic [7:0]        w_shift_nx;
    logic              r_tx;
    logic              w_tx_nx;
    logic              w_baud_last;

    // Bit timer, state and line registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_baud  <= '0;
            r_bit   <= 3'd0;
            r_shift <= 8'd0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_nx;
            r_baud  <= w_baud_nx;
            r_bit   <= w_bit_nx;
            r_shift <= w_shift_nx;
            r_tx    <= w_tx_nx;
        end
    end

    // Next-state logic; the line value is computed one cycle ahead so tx is a flop.
    always_comb begin
        w_state_nx  = r_state;
        w_baud_nx   = r_baud;
        w_bit_nx    = r_bit;
        w_shift_nx  = r_shift;
        w_tx_nx     = r_tx;
        w_baud_last = (r_baud == BAUD_LAST);
        o_ready     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                o_ready = 1'b1;
                w_tx_nx = 1'b1;
                if (i_start) begin
                    w_state_nx = ST_START;
                    w_baud_nx  = '0;
                    w_shift_nx = i_data;
                    w_tx_nx    = 1'b0;
                end else begin
                    w_state_nx = ST_IDLE;
                end
            end
            ST_START: begin
                if (w_baud_last) begin
                    w_state_nx = ST_DATA;
                    w_baud_nx  = '0;
                    w_bit_nx   = 3'd0;
                    w_tx_nx    = r_shift[0];
                end else begin
                    w_baud_nx  = r_baud + BAUD_W'(1);
                end
            end
            ST_DATA: begin
                if (w_baud_last) begin
                    w_baud_nx = '0;
                    if (r_bit == 3'd7) begin
                        w_state_nx = ST_STOP;
                        w_tx_nx    = 1'b1;
                    end else begin
                        w_bit_nx   = r_bit + 3'd1;
                        w_shift_nx = {1'b0, r_shift[7:1]};
                        w_tx_nx    = r_shift[1];
                    end
                end else begin
                    w_baud_nx = r_baud + BAUD_W'(1);
                end
            end
            ST_STOP: begin
                o_ready = w_baud_last;
                if (w_baud_last) begin
                    w_baud_nx = '0;
                    if (i_start) begin
                        w_state_nx = ST_START;
                        w_shift_nx = i_data;
                        w_tx_nx    = 1'b0;
                    end else begin
                        w_state_nx = ST_IDLE;
                        w_tx_nx    = 1'b1;
                    end
                end else begin
                    w_baud_nx = r_baud + BAUD_W'(1);
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
                w_baud_nx  = '0;
                w_bit_nx   = 3'd0;
                w_tx_nx    = 1'b1;
            end
        endcase
    end

    assign o_tx = r_tx;

endmodule

// File: rtl/num_uart_tx.sv
// Sends N_NUMS 16-bit values as a contiguous stream of 8N1 bytes,
// low byte first, element 0 first, from a snapshot taken at acceptance.
module num_uart_tx
    import p3p_pkg::*;
#(
    parameter int N_NUMS       = 1,
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              send_data,
    input  num   [N_NUMS-1:0] tx_nums,
    output logic              tx,
    output logic              busy,
    output logic              done
);

    localparam int               IDX_W   = $clog2(2 * N_NUMS) + 1;
    localparam logic [IDX_W-1:0] N_BYTES = IDX_W'(2 * N_NUMS);

    num   [N_NUMS-1:0] r_buf;
    logic [IDX_W-1:0]  r_byte_idx;
    logic              r_busy;
    logic              r_done;

    logic              w_ready;
    logic              w_tx;
    logic              w_accept;
    logic              w_more;
    logic              w_finish;
    logic              w_start;
    logic [7:0]        w_buf_byte;
    logic [7:0]        w_byte;

    // Byte-level handshake: first byte comes straight from the inputs, the rest from the snapshot.
    always_comb begin
        w_accept   = !r_busy && w_ready && send_data;
        w_more     = r_busy && w_ready && (r_byte_idx < N_BYTES);
        w_finish   = r_busy && w_ready && (r_byte_idx >= N_BYTES);
        w_start    = w_accept || w_more;
        w_buf_byte = 8'd0;
        for (int i = 0; i < 2 * N_NUMS; i++) begin
            w_buf_byte = w_buf_byte |
                         ({8{r_byte_idx == IDX_W'(i)}} & num_byte(r_buf[i / 2], i[0]));
        end
        w_byte = w_accept ? num_byte(tx_nums[0], 1'b0) : w_buf_byte;
    end

    // Snapshot buffer, byte sequencing and the busy/done flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_buf      <= '0;
            r_byte_idx <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else if (w_accept) begin
            r_buf      <= tx_nums;
            r_byte_idx <= IDX_W'(1);
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
        end else if (w_more) begin
            r_byte_idx <= r_byte_idx + IDX_W'(1);
            r_done     <= 1'b0;
        end else if (w_finish) begin
            r_byte_idx <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
        end else begin
            r_done     <= 1'b0;
        end
    end

    uart_byte_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte_tx (
        .clk     (clk),
        .reset   (reset),
        .i_start (w_start),
        .i_data  (w_byte),
        .o_ready (w_ready),
        .o_tx    (w_tx)
    );

    assign tx   = w_tx;
    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: tb/tb_num_uart_tx.sv
// Bench for num_uart_tx: one single-value and one five-value instance,
// expected bytes queued at stimulus time and checked cycle by cycle on tx.
module tb_num_uart_tx;
    import p3p_pkg::*;

    localparam int CPB = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst1  = 1'b1;
    logic       send1 = 1'b0;
    num   [0:0] nums1 = '0;
    logic       tx1, busy1, done1;

    logic       rst5  = 1'b1;
    logic       send5 = 1'b0;
    num   [4:0] nums5 = '0;
    logic       tx5, busy5, done5;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] sb[$];

    num_uart_tx #(.N_NUMS(1), .CLKS_PER_BIT(CPB)) dut1 (
        .clk(clk), .reset(rst1), .send_data(send1), .tx_nums(nums1),
        .tx(tx1), .busy(busy1), .done(done1)
    );

    num_uart_tx #(.N_NUMS(5), .CLKS_PER_BIT(CPB)) dut5 (
        .clk(clk), .reset(rst5), .send_data(send5), .tx_nums(nums5),
        .tx(tx5), .busy(busy5), .done(done5)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic get_tx(input int sel);
        if (sel == 5) return tx5; else return tx1;
    endfunction

    function automatic logic get_busy(input int sel);
        if (sel == 5) return busy5; else return busy1;
    endfunction

    function automatic logic get_done(input int sel);
        if (sel == 5) return done5; else return done1;
    endfunction

    // Walks nbytes*10*CPB cycles starting at the first start-bit cycle; every
    // cycle must match the expected 8N1 pattern with busy high and done low.
    task automatic rx_frame(input int sel, input int nbytes, input bit disturb);
        for (int b = 0; b < nbytes; b++) begin
            logic [7:0] exp_b;
            logic [7:0] obs_b;
            logic [9:0] pat;
            bit         ok;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_empty dut%0d byte%0d: got empty queue, required an entry", sel, b);
                exp_b = 8'h00;
            end else begin
                exp_b = sb.pop_front();
            end
            pat   = {1'b1, exp_b, 1'b0};
            ok    = 1'b1;
            obs_b = 8'h00;
            if (disturb && b == 2) begin
                send5 = 1'b1;
                for (int n = 0; n < 5; n++) nums5[n] = 16'shFFFF;
            end
            if (disturb && b == 6) send5 = 1'b0;
            for (int k = 0; k < 10; k++) begin
                for (int c = 0; c < CPB; c++) begin
                    if (get_tx(sel) !== pat[k] || get_busy(sel) !== 1'b1 || get_done(sel) !== 1'b0)
                        ok = 1'b0;
                    if (k >= 1 && k <= 8 && c == CPB / 2) obs_b[k-1] = get_tx(sel);
                    tick();
                end
            end
            checks++;
            if (!ok || obs_b !== exp_b) begin
                errors++;
                $display("FAIL byte dut%0d idx%0d: got %02h (cycle_timing_ok=%0d), required %02h",
                         sel, b, obs_b, ok, exp_b);
            end
        end
    endtask

    task automatic test_reset();
        #2;
        rst1 = 1'b0;
        rst5 = 1'b0;
        repeat (3) tick();
        checks++; if (tx1 !== 1'b1)   begin errors++; $display("FAIL reset_tx1: got %b required 1", tx1); end
        checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL reset_busy1: got %b required 0", busy1); end
        checks++; if (done1 !== 1'b0) begin errors++; $display("FAIL reset_done1: got %b required 0", done1); end
        checks++; if (tx5 !== 1'b1)   begin errors++; $display("FAIL reset_tx5: got %b required 1", tx5); end
        checks++; if (busy5 !== 1'b0) begin errors++; $display("FAIL reset_busy5: got %b required 0", busy5); end
        checks++; if (done5 !== 1'b0) begin errors++; $display("FAIL reset_done5: got %b required 0", done5); end
        rst1 = 1'b1;
        rst5 = 1'b1;
        tick();
    endtask

    task automatic test_single(input num value, input string name);
        nums1[0] = value;
        sb.push_back(value[7:0]);
        sb.push_back(value[15:8]);
        send1 = 1'b1;
        tick();
        send1 = 1'b0;
        checks++;
        if (tx1 !== 1'b0 || busy1 !== 1'b1) begin
            errors++;
            $display("FAIL %s_latency: got tx=%b busy=%b required tx=0 busy=1", name, tx1, busy1);
        end
        rx_frame(1, 2, 1'b0);
        checks++;
        if (done1 !== 1'b1 || busy1 !== 1'b0 || tx1 !== 1'b1) begin
            errors++;
            $display("FAIL %s_done: got done=%b busy=%b tx=%b required 1 0 1", name, done1, busy1, tx1);
        end
        tick();
        checks++;
        if (done1 !== 1'b0) begin errors++; $display("FAIL %s_done_width: got %b required 0", name, done1); end
    endtask

    task automatic test_five(input bit disturb, input string name);
        for (int n = 0; n < 5; n++) begin
            nums5[n] = disturb ? num'(16'h1100 + n) : num'(n + 1);
            sb.push_back(disturb ? 8'(n) : 8'(n + 1));
            sb.push_back(disturb ? 8'h11 : 8'h00);
        end
        send5 = 1'b1;
        tick();
        send5 = 1'b0;
        checks++;
        if (tx5 !== 1'b0 || busy5 !== 1'b1) begin
            errors++;
            $display("FAIL %s_latency: got tx=%b busy=%b required tx=0 busy=1", name, tx5, busy5);
        end
        rx_frame(5, 10, disturb);
        checks++;
        if (done5 !== 1'b1 || busy5 !== 1'b0) begin
            errors++;
            $display("FAIL %s_done: got done=%b busy=%b required 1 0", name, done5, busy5);
        end
        tick();
        checks++;
        if (done5 !== 1'b0 || tx5 !== 1'b1) begin
            errors++;
            $display("FAIL %s_after: got done=%b tx=%b required 0 1", name, done5, tx5);
        end
    endtask

    task automatic test_abort();
        bit saw_done;
        nums1[0] = 16'sh5A3C;
        send1 = 1'b1;
        tick();
        send1 = 1'b0;
        repeat (6) tick();
        #2;
        rst1 = 1'b0;
        #1;
        checks++;
        if (tx1 !== 1'b1 || busy1 !== 1'b0) begin
            errors++;
            $display("FAIL abort_immediate: got tx=%b busy=%b required tx=1 busy=0", tx1, busy1);
        end
        saw_done = 1'b0;
        repeat (3) begin
            tick();
            if (done1 !== 1'b0) saw_done = 1'b1;
        end
        checks++;
        if (saw_done) begin errors++; $display("FAIL abort_no_done: got done pulse, required none"); end
        nums1[0] = 16'sh00AA;
        sb.push_back(8'hAA);
        sb.push_back(8'h00);
        send1 = 1'b1;
        rst1  = 1'b1;
        tick();
        send1 = 1'b0;
        checks++;
        if (tx1 !== 1'b0 || busy1 !== 1'b1) begin
            errors++;
            $display("FAIL abort_restart: got tx=%b busy=%b required tx=0 busy=1", tx1, busy1);
        end
        rx_frame(1, 2, 1'b0);
        checks++;
        if (done1 !== 1'b1) begin errors++; $display("FAIL abort_frame_done: got %b required 1", done1); end
        tick();
    endtask

    task automatic test_back_to_back();
        nums1[0] = 16'shBEEF;
        sb.push_back(8'hEF);
        sb.push_back(8'hBE);
        send1 = 1'b1;
        tick();
        nums1[0] = 16'shC3A5;
        rx_frame(1, 2, 1'b0);
        checks++;
        if (done1 !== 1'b1 || tx1 !== 1'b1) begin
            errors++;
            $display("FAIL b2b_done: got done=%b tx=%b required 1 1", done1, tx1);
        end
        sb.push_back(8'hA5);
        sb.push_back(8'hC3);
        tick();
        send1 = 1'b0;
        checks++;
        if (tx1 !== 1'b0 || busy1 !== 1'b1 || done1 !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second_start: got tx=%b busy=%b done=%b required 0 1 0", tx1, busy1, done1);
        end
        rx_frame(1, 2, 1'b0);
        checks++;
        if (done1 !== 1'b1) begin errors++; $display("FAIL b2b_second_done: got %b required 1", done1); end
        tick();
        checks++;
        if (busy1 !== 1'b0 || done1 !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle: got busy=%b done=%b required 0 0", busy1, done1);
        end
    endtask

    initial begin
        test_reset();
        test_single(16'sh1234, "basic");
        test_single(-16'sd2, "negative");
        test_five(1'b0, "five");
        test_five(1'b1, "midframe");
        test_abort();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
